bullet_engine: RTL and testbench

Bullet engine for Starflux: owns a fixed pool of player bullets, spawns them at the player ship on a fire request, advances them one row per frame tick and retires them at the far edge of the playfield. It sits directly upstream of the display scan stage. The display presents its current scan coordinate on the query port, and this block returns a registered "bullet at this pixel" flag that the display uses to paint bullets green. The 160×120 one-bit-per-pixel bitmap is replaced by a compact slot table.

---
 rtl/starflux_pkg.sv | 20 ++
 rtl/bullet_slot.sv | 51 +++++
 rtl/bullet_engine.sv | 115 +++++++++++
 tb/tb_bullet_engine.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/starflux_pkg.sv
// Shared Starflux definitions: playfield geometry, colour codes and the bullet slot record.
package starflux_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;

  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] BLACK = 3'b000;

  typedef struct packed {
    logic           valid;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } bullet_t;

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: spawn load, per-frame advance/retire, and a pixel-match compare.
module bullet_slot
  import starflux_pkg::*;
#(
  parameter int unsigned LAST_ROW = SCREEN_H - 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       tick,
  input  logic [7:0] load_x,
  input  logic [6:0] load_y,
  input  logic [7:0] query_x,
  input  logic [6:0] query_y,
  output logic       slot_valid,
  output logic       next_valid_c,
  output logic       hit_c
);

  bullet_t slot_q, slot_d;

  // Advance existing bullets; a load only ever targets a slot that was free, so it simply wins.
  always_comb begin
    slot_d = slot_q;
    if (tick && slot_q.valid) begin
      if (32'(slot_q.y) == LAST_ROW) begin
        slot_d.valid = 1'b0;
      end else begin
        slot_d.y = slot_q.y + 7'd1;
      end
    end
    if (load) begin
      slot_d.valid = 1'b1;
      slot_d.x     = load_x;
      slot_d.y     = load_y;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_valid   = slot_q.valid;
  assign next_valid_c = slot_d.valid;
  assign hit_c        = slot_q.valid && (slot_q.x == query_x) && (slot_q.y == query_y);

endmodule

// File: rtl/bullet_engine.sv
// Player bullet pool: fire acceptance with cooldown, per-frame movement and a
// registered per-pixel occupancy lookup for the display scan stage.
module bullet_engine
  import starflux_pkg::*;
#(
  parameter int unsigned NUM_BULLETS   = 8,
  parameter int unsigned SCREEN_W      = starflux_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H      = starflux_pkg::SCREEN_H,
  parameter int unsigned FIRE_COOLDOWN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic [7:0] ship_x,
  input  logic [6:0] ship_y,
  input  logic [7:0] query_x,
  input  logic [6:0] query_y,
  output logic       bullet_px,
  output logic       fire_ack,
  output logic [3:0] active_count
);

  localparam int unsigned CD_W = (FIRE_COOLDOWN > 1) ? $clog2(FIRE_COOLDOWN + 1) : 1;

  logic [NUM_BULLETS-1:0] valid;
  logic [NUM_BULLETS-1:0] next_valid;
  logic [NUM_BULLETS-1:0] hit;
  logic [NUM_BULLETS-1:0] free_onehot_c;
  logic [NUM_BULLETS-1:0] load_c;

  logic            any_free_c;
  logic            ship_ok_c;
  logic            query_ok_c;
  logic            fire_ok_c;
  logic [6:0]      spawn_y_c;

  logic [CD_W-1:0] cd_q, cd_d;
  logic            bullet_px_q, bullet_px_d;
  logic            fire_ack_q, fire_ack_d;
  logic [3:0]      active_count_q, active_count_d;

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
    bullet_slot #(
      .LAST_ROW(SCREEN_H - 1)
    ) u_slot (
      .clk         (clk),
      .reset       (reset),
      .load        (load_c[g]),
      .tick        (frame_tick),
      .load_x      (ship_x),
      .load_y      (spawn_y_c),
      .query_x     (query_x),
      .query_y     (query_y),
      .slot_valid  (valid[g]),
      .next_valid_c(next_valid[g]),
      .hit_c       (hit[g])
    );
  end

  // Lowest-index free slot, judged on start-of-cycle valid bits so same-cycle retirees stay busy.
  always_comb begin
    free_onehot_c = '0;
    any_free_c    = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!valid[i] && !any_free_c) begin
        free_onehot_c[i] = 1'b1;
        any_free_c       = 1'b1;
      end
    end
  end

  assign ship_ok_c  = (32'(ship_x) < SCREEN_W) && (32'(ship_y) < SCREEN_H - 1);
  assign query_ok_c = (32'(query_x) < SCREEN_W) && (32'(query_y) < SCREEN_H);
  assign fire_ok_c  = fire && (cd_q == '0) && any_free_c && ship_ok_c;
  assign load_c     = free_onehot_c & {NUM_BULLETS{fire_ok_c}};
  assign spawn_y_c  = ship_y + 7'd1;

  // Cooldown ticks down first; a fire can only be accepted from a zero start value.
  always_comb begin
    cd_d = cd_q;
    if (frame_tick && (cd_q != '0)) begin
      cd_d = cd_q - CD_W'(1);
    end
    if (fire_ok_c) begin
      cd_d = CD_W'(FIRE_COOLDOWN);
    end

    fire_ack_d     = fire_ok_c;
    bullet_px_d    = query_ok_c && (|hit);
    active_count_d = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      active_count_d = active_count_d + 4'(next_valid[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cd_q           <= '0;
      bullet_px_q    <= 1'b0;
      fire_ack_q     <= 1'b0;
      active_count_q <= '0;
    end else begin
      cd_q           <= cd_d;
      bullet_px_q    <= bullet_px_d;
      fire_ack_q     <= fire_ack_d;
      active_count_q <= active_count_d;
    end
  end

  assign bullet_px    = bullet_px_q;
  assign fire_ack     = fire_ack_q;
  assign active_count = active_count_q;

endmodule

// File: tb/tb_bullet_engine.sv
// Scoreboard bench for bullet_engine: the driver queues per-cycle expectations,
// a monitor pops and checks them just after each rising edge.
module tb_bullet_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       fire;
  logic [7:0] ship_x;
  logic [6:0] ship_y;
  logic [7:0] query_x;
  logic [6:0] query_y;
  logic       bullet_px;
  logic       fire_ack;
  logic [3:0] active_count;

  always #5 clk = ~clk;

  bullet_engine #(
    .NUM_BULLETS  (8),
    .SCREEN_W     (160),
    .SCREEN_H     (120),
    .FIRE_COOLDOWN(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .fire        (fire),
    .ship_x      (ship_x),
    .ship_y      (ship_y),
    .query_x     (query_x),
    .query_y     (query_y),
    .bullet_px   (bullet_px),
    .fire_ack    (fire_ack),
    .active_count(active_count)
  );

  // A negative expectation means "don't check this output this cycle".
  typedef struct {
    int    px;
    int    ack;
    int    cnt;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;

  task automatic chk(input string tag, input string what, input logic [3:0] act, input int expv);
    vectors++;
    if (act !== 4'(expv)) begin
      errors++;
      $display("FAIL %s %s: got %0d, expected %0d", tag, what, act, expv);
    end
  endtask

  task automatic cyc(input logic r, input logic t, input logic f,
                     input int sx, input int sy, input int qx, input int qy,
                     input int epx, input int eack, input int ecnt, input string tag);
    exp_t e;
    reset      = r;
    frame_tick = t;
    fire       = f;
    ship_x     = 8'(sx);
    ship_y     = 7'(sy);
    query_x    = 8'(qx);
    query_y    = 7'(qy);
    e.px  = epx;
    e.ack = eack;
    e.cnt = ecnt;
    e.tag = tag;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.px >= 0)  chk(e.tag, "bullet_px", {3'b000, bullet_px}, e.px);
        if (e.ack >= 0) chk(e.tag, "fire_ack", {3'b000, fire_ack}, e.ack);
        if (e.cnt >= 0) chk(e.tag, "active_count", active_count, e.cnt);
      end
    end
  end

  initial begin
    // Reset and first bullet
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset0");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset1");
    cyc(0, 0, 1, 40, 0, 0, 0, 0, 1, 1, "fire40");
    cyc(0, 0, 0, 0, 0, 40, 1, 1, 0, 1, "q40_1");
    cyc(0, 0, 0, 0, 0, 41, 1, 0, 0, 1, "q41_1");

    // March to the last row; query each tick cycle sees the pre-tick position
    for (int k = 0; k < 118; k++) begin
      cyc(0, 1, 0, 0, 0, 40, 1 + k, 1, 0, 1, "march");
    end
    cyc(0, 0, 0, 0, 0, 40, 119, 1, 0, 1, "q_last");
    cyc(0, 0, 0, 0, 0, 40, 118, 0, 0, 1, "q_prev_row");
    cyc(0, 1, 0, 0, 0, 40, 119, 1, 0, 0, "retire");
    cyc(0, 0, 0, 0, 0, 40, 119, 0, 0, 0, "gone");
    cyc(0, 0, 0, 0, 0, 40, 0, 0, 0, 0, "no_wrap");

    // Out-of-range ship and query coordinates
    cyc(0, 0, 1, 170, 0, 0, 0, -1, 0, 0, "bad_ship_x");
    cyc(0, 0, 1, 10, 119, 0, 0, -1, 0, 0, "bad_ship_y");
    cyc(0, 0, 1, 10, 118, 0, 0, -1, 1, 1, "edge_ship_y");
    cyc(0, 0, 0, 0, 0, 10, 119, 1, 0, 1, "q_edge");
    cyc(0, 0, 0, 0, 0, 200, 119, 0, 0, 1, "q_oob_x");

    // Auto-repeat: fire held, tick every third cycle, accepts every 4 ticks until full
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset2");
    for (int c = 0; c < 98; c++) begin
      int ecnt;
      ecnt = (c / 12 + 1 > 8) ? 8 : c / 12 + 1;
      cyc(0, (c % 3) == 2, 1, 20, 0, 0, 0, -1, ((c % 12) == 0 && c <= 84) ? 1 : 0, ecnt, "repeat");
    end

    // Drive slot 0 (y=33) to the last row, tracking it with queries
    for (int k = 0; k < 86; k++) begin
      cyc(0, 1, 0, 0, 0, 20, 33 + k, 1, 0, 8, "drift");
    end
    cyc(0, 1, 1, 20, 0, 20, 119, 1, 0, 7, "full_retire");
    cyc(0, 0, 1, 20, 0, 20, 119, 0, 1, 8, "reuse");
    cyc(0, 0, 0, 0, 0, 20, 1, 1, 0, 8, "q_reused");
    cyc(0, 0, 0, 0, 0, 20, 116, 1, 0, 8, "q_slot1");

    // Same-cycle fire and tick
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset3");
    cyc(0, 0, 1, 50, 45, 0, 0, -1, 1, 1, "spawn50");
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 0, 0, 0, 0, 0, -1, 0, 1, "settle");
    end
    cyc(0, 1, 1, 60, 10, 50, 50, 1, 1, 2, "tick_fire");
    cyc(0, 0, 0, 0, 0, 50, 51, 1, 0, 2, "q_moved");
    cyc(0, 0, 0, 0, 0, 60, 11, 1, 0, 2, "q_spawn");
    cyc(0, 0, 0, 0, 0, 60, 12, 0, 0, 2, "q_spawn_next");
    cyc(0, 0, 0, 0, 0, 50, 50, 0, 0, 2, "q_old_pos");

    // Build 5 bullets, leave cooldown at 3, then reset mid-frame
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) begin
        cyc(0, 1, 1, 30, 0, 0, 0, -1, 0, 2 + r, "cooldown");
      end
      cyc(0, 0, 1, 30, 0, 0, 0, -1, 1, 3 + r, "refire");
    end
    cyc(0, 1, 0, 0, 0, 0, 0, -1, 0, 5, "cd3");
    cyc(1, 1, 1, 30, 0, 30, 1, 0, 0, 0, "reset_mid");
    cyc(0, 0, 1, 30, 0, 0, 0, -1, 1, 1, "post_reset_fire");

    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
